// File: rtl/mc_ctrl_unit.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing with
// handshaked memories, branch resolution, traps and a retired-instruction counter.
module mc_ctrl_unit #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 alu_zero,
  input  logic                 alu_lt,
  input  logic                 alu_ltu,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 dmem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 rf_we,
  output logic [1:0]           pc_src,
  output logic [1:0]           alu_src_a,
  output logic                 alu_src_b,
  output logic [2:0]           imm_sel,
  output logic [3:0]           alu_cmd,
  output logic [1:0]           rf_src,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_WIDTH-1:0] instret,
  output logic [2:0]           state
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_e;

  state_e               state_q, state_d;
  cls_e                 cls_q, cls_d;
  logic [2:0]           funct3_q, funct3_d;
  logic                 f7_q, f7_d;
  logic [1:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 taken;
  logic                 timeout_hit;
  logic [2:0]           cls_imm;
  logic                 unused_instr_bits;

  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  function automatic logic [3:0] f3_cmd(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Branch condition from the ALU flags of rs1-rs2
  always_comb begin
    case (funct3_q)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    case (cls_q)
      C_STORE:        cls_imm = 3'd1;
      C_BRANCH:       cls_imm = 3'd2;
      C_LUI, C_AUIPC: cls_imm = 3'd3;
      C_JAL:          cls_imm = 3'd4;
      default:        cls_imm = 3'd0;
    endcase
  end

  // The counter only ever holds values below MEM_TIMEOUT; the last miss traps
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cls_q     <= C_R;
      funct3_q  <= 3'd0;
      f7_q      <= 1'b0;
      cause_q   <= 2'b00;
      instret_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      funct3_q  <= funct3_d;
      f7_q      <= f7_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    funct3_d  = funct3_q;
    f7_d      = f7_q;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    pc_src    = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 1'b0;
    imm_sel   = 3'd0;
    alu_cmd   = ALU_ADD;
    rf_src    = 2'd0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          cause_d = 2'b10;
          state_d = S_TRAP;
        end
      end

      S_DECODE: begin
        funct3_d = instr[14:12];
        f7_d     = instr[30];
        state_d  = S_EXECUTE;
        case (instr[6:0])
          7'b0110011: cls_d = C_R;
          7'b0010011: cls_d = C_I;
          7'b0000011: cls_d = C_LOAD;
          7'b0100011: cls_d = C_STORE;
          7'b1100011: cls_d = C_BRANCH;
          7'b1101111: cls_d = C_JAL;
          7'b1100111: cls_d = C_JALR;
          7'b0110111: cls_d = C_LUI;
          7'b0010111: cls_d = C_AUIPC;
          default: begin
            cause_d = 2'b01;
            state_d = S_TRAP;
          end
        endcase
      end

      S_EXECUTE: begin
        imm_sel = cls_imm;
        state_d = S_WRITEBACK;
        case (cls_q)
          C_R:     alu_cmd = f3_cmd(funct3_q, f7_q);
          C_I: begin
            alu_src_b = 1'b1;
            alu_cmd   = f3_cmd(funct3_q, f7_q && (funct3_q == 3'b101));
          end
          C_LOAD, C_STORE: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          C_BRANCH: begin
            alu_cmd = ALU_SUB;
            pc_we   = 1'b1;
            pc_src  = taken ? 2'd1 : 2'd0;
            state_d = S_FETCH;
          end
          C_JALR:  alu_src_b = 1'b1;
          C_LUI: begin
            alu_src_a = 2'd2;
            alu_src_b = 1'b1;
          end
          C_AUIPC: begin
            alu_src_a = 2'd1;
            alu_src_b = 1'b1;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        imm_sel  = cls_imm;
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        if (dmem_ready) begin
          if (cls_q == C_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (timeout_hit) begin
          cause_d = 2'b11;
          state_d = S_TRAP;
        end
      end

      S_WRITEBACK: begin
        imm_sel = cls_imm;
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        case (cls_q)
          C_LOAD:  rf_src = 2'd1;
          C_JAL: begin
            rf_src = 2'd2;
            pc_src = 2'd1;
          end
          C_JALR: begin
            rf_src = 2'd2;
            pc_src = 2'd2;
          end
          default: ;
        endcase
      end

      default: ;
    endcase

    instret_d = pc_we ? instret_q + CNT_WIDTH'(1) : instret_q;

    if (state_d != state_q)
      wait_d = '0;
    else if ((MEM_TIMEOUT != 0) && ((imem_req && !imem_ready) || (dmem_req && !dmem_ready)))
      wait_d = wait_q + WAIT_W'(1);
    else
      wait_d = wait_q;
  end

  assign state      = state_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit: per-class control words, memory waits,
// branches, traps and reset behaviour against hand-computed expectations.
module tb_mc_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        alu_zero, alu_lt, alu_ltu;
  logic        imem_req, imem_ready, dmem_req, dmem_ready, dmem_we;
  logic        ir_we, pc_we, rf_we;
  logic [1:0]  pc_src, alu_src_a, rf_src, trap_cause;
  logic        alu_src_b, trap;
  logic [2:0]  imm_sel, state;
  logic [3:0]  alu_cmd;
  logic [31:0] instret;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned exp_ret = 0;

  always #5 clk = ~clk;

  mc_ctrl_unit #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_sel(imm_sel), .alu_cmd(alu_cmd), .rf_src(rf_src),
    .trap(trap), .trap_cause(trap_cause), .instret(instret), .state(state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the IDLE cycle that follows reset
  task automatic do_reset;
    reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
    tick; tick;
    reset = 1'b0; exp_ret = 0;
    #1;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
    n_cmp++; if (instret !== 32'd0) begin n_err++; $display("FAIL reset_instret got %0d exp 0", instret); end
    n_cmp++; if ({trap, trap_cause} !== 3'b000) begin n_err++; $display("FAIL reset_trap got %b exp 000", {trap, trap_cause}); end
    n_cmp++; if ({imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we} !== 6'b0) begin
      n_err++; $display("FAIL reset_enables got %b exp 000000", {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we}); end
    n_cmp++; if ({pc_src, alu_src_a, alu_src_b, imm_sel, alu_cmd, rf_src} !== 14'b0) begin
      n_err++; $display("FAIL reset_selects got %b exp 0", {pc_src, alu_src_a, alu_src_b, imm_sel, alu_cmd, rf_src}); end
    tick;
  endtask

  // One instruction that retires through WRITEBACK with zero-wait fetch; starts and ends in FETCH
  task automatic run_wb_instr(input string nm, input logic [31:0] ins, input logic [1:0] ea,
                              input logic eb, input logic [2:0] eimm, input logic [3:0] ecmd,
                              input logic [1:0] erf, input logic [1:0] epc);
    instr = ins; imem_ready = 1'b1; #1;
    n_cmp++; if ({state, imem_req, ir_we} !== {3'd1, 2'b11}) begin
      n_err++; $display("FAIL %s fetch state=%0d req=%b ir_we=%b exp 1 1 1", nm, state, imem_req, ir_we); end
    tick; imem_ready = 1'b0;
    n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL %s decode_state got %0d exp 2", nm, state); end
    tick;
    n_cmp++; if ({state, alu_src_a, alu_src_b, imm_sel, alu_cmd} !== {3'd3, ea, eb, eimm, ecmd}) begin
      n_err++; $display("FAIL %s execute st=%0d a=%0d b=%0d imm=%0d cmd=%0d exp 3 %0d %0d %0d %0d",
                        nm, state, alu_src_a, alu_src_b, imm_sel, alu_cmd, ea, eb, eimm, ecmd); end
    n_cmp++; if ({pc_we, rf_we} !== 2'b00) begin n_err++; $display("FAIL %s execute_we got %b exp 00", nm, {pc_we, rf_we}); end
    tick;
    n_cmp++; if ({state, rf_we, pc_we, rf_src, pc_src} !== {3'd5, 2'b11, erf, epc}) begin
      n_err++; $display("FAIL %s writeback st=%0d rf_we=%b pc_we=%b rf_src=%0d pc_src=%0d exp 5 1 1 %0d %0d",
                        nm, state, rf_we, pc_we, rf_src, pc_src, erf, epc); end
    tick; exp_ret++;
    n_cmp++; if ({state, instret} !== {3'd1, exp_ret}) begin
      n_err++; $display("FAIL %s retire st=%0d instret=%0d exp 1 %0d", nm, state, instret, exp_ret); end
  endtask

  task automatic test_r_i_types;
    run_wb_instr("add",    32'h002081B3, 2'd0, 1'b0, 3'd0, 4'd0, 2'd0, 2'd0);
    run_wb_instr("sub",    32'h402081B3, 2'd0, 1'b0, 3'd0, 4'd1, 2'd0, 2'd0);
    run_wb_instr("srai",   32'h4020D193, 2'd0, 1'b1, 3'd0, 4'd7, 2'd0, 2'd0);
    run_wb_instr("addi30", 32'h40008193, 2'd0, 1'b1, 3'd0, 4'd0, 2'd0, 2'd0);
  endtask

  task automatic test_jumps_upper;
    run_wb_instr("jal",   32'h008000EF, 2'd0, 1'b0, 3'd4, 4'd0, 2'd2, 2'd1);
    run_wb_instr("jalr",  32'h000100E7, 2'd0, 1'b1, 3'd0, 4'd0, 2'd2, 2'd2);
    run_wb_instr("lui",   32'h123450B7, 2'd2, 1'b1, 3'd3, 4'd0, 2'd0, 2'd0);
    run_wb_instr("auipc", 32'h00001097, 2'd1, 1'b1, 3'd3, 4'd0, 2'd0, 2'd0);
  endtask

  // LW with dmem_ready arriving on the 4th MEM cycle, also the last cycle before the timeout
  task automatic test_load_wait;
    instr = 32'h0000A183; imem_ready = 1'b1; #1;
    n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL lw fetch_state got %0d exp 1", state); end
    tick; imem_ready = 1'b0;
    tick;
    n_cmp++; if ({state, alu_src_b, imm_sel, alu_cmd} !== {3'd3, 1'b1, 3'd0, 4'd0}) begin
      n_err++; $display("FAIL lw execute st=%0d b=%0d imm=%0d cmd=%0d exp 3 1 0 0", state, alu_src_b, imm_sel, alu_cmd); end
    tick;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3); #1;
      n_cmp++; if ({state, dmem_req, dmem_we, pc_we} !== {3'd4, 3'b100}) begin
        n_err++; $display("FAIL lw mem%0d st=%0d req=%b we=%b pc_we=%b exp 4 1 0 0", i, state, dmem_req, dmem_we, pc_we); end
      tick;
    end
    dmem_ready = 1'b0;
    n_cmp++; if ({state, rf_we, rf_src, pc_we} !== {3'd5, 1'b1, 2'd1, 1'b1}) begin
      n_err++; $display("FAIL lw writeback st=%0d rf_we=%b rf_src=%0d pc_we=%b exp 5 1 1 1", state, rf_we, rf_src, pc_we); end
    tick; exp_ret++;
    n_cmp++; if ({state, instret} !== {3'd1, exp_ret}) begin
      n_err++; $display("FAIL lw retire st=%0d instret=%0d exp 1 %0d", state, instret, exp_ret); end
  endtask

  task automatic run_branch(input string nm, input logic [31:0] ins, input logic z, input logic lt,
                            input logic ltu, input logic [1:0] exp_src);
    instr = ins; imem_ready = 1'b1; alu_zero = z; alu_lt = lt; alu_ltu = ltu; #1;
    n_cmp++; if ({state, rf_we} !== {3'd1, 1'b0}) begin n_err++; $display("FAIL %s fetch st=%0d rf_we=%b exp 1 0", nm, state, rf_we); end
    tick; imem_ready = 1'b0;
    n_cmp++; if ({state, rf_we} !== {3'd2, 1'b0}) begin n_err++; $display("FAIL %s decode st=%0d rf_we=%b exp 2 0", nm, state, rf_we); end
    tick;
    n_cmp++; if ({state, pc_we, pc_src, rf_we, alu_cmd, alu_src_b, imm_sel} !== {3'd3, 1'b1, exp_src, 1'b0, 4'd1, 1'b0, 3'd2}) begin
      n_err++; $display("FAIL %s execute st=%0d pc_we=%b pc_src=%0d rf_we=%b cmd=%0d b=%0d imm=%0d exp 3 1 %0d 0 1 0 2",
                        nm, state, pc_we, pc_src, rf_we, alu_cmd, alu_src_b, imm_sel, exp_src); end
    tick; exp_ret++;
    n_cmp++; if ({state, instret} !== {3'd1, exp_ret}) begin
      n_err++; $display("FAIL %s retire st=%0d instret=%0d exp 1 %0d", nm, state, instret, exp_ret); end
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
  endtask

  task automatic test_branch;
    run_branch("beq_t",  32'h00208463, 1'b1, 1'b0, 1'b0, 2'd1);
    run_branch("beq_n",  32'h00208463, 1'b0, 1'b1, 1'b1, 2'd0);
    run_branch("blt_t",  32'h0020C463, 1'b0, 1'b1, 1'b0, 2'd1);
    run_branch("bgeu_n", 32'h0020F463, 1'b0, 1'b0, 1'b1, 2'd0);
  endtask

  task automatic test_store_and_reset;
    do_reset; tick;
    for (int pass = 0; pass < 2; pass++) begin
      instr = 32'h0020A023; imem_ready = 1'b1; #1;
      tick; imem_ready = 1'b0;
      tick;
      n_cmp++; if ({state, alu_src_b, imm_sel, alu_cmd} !== {3'd3, 1'b1, 3'd1, 4'd0}) begin
        n_err++; $display("FAIL sw%0d execute st=%0d b=%0d imm=%0d cmd=%0d exp 3 1 1 0", pass, state, alu_src_b, imm_sel, alu_cmd); end
      tick;
      dmem_ready = (pass == 1); #1;
      n_cmp++; if ({state, dmem_req, dmem_we, pc_we, pc_src} !== {3'd4, 2'b11, (pass == 1), 2'd0}) begin
        n_err++; $display("FAIL sw%0d mem st=%0d req=%b we=%b pc_we=%b pc_src=%0d exp 4 1 1 %0d 0",
                          pass, state, dmem_req, dmem_we, pc_we, pc_src, pass); end
      if (pass == 0) begin
        reset = 1'b1; tick; reset = 1'b0; #1;
        n_cmp++; if ({state, dmem_req, dmem_we, pc_we, instret} !== {3'd0, 3'b000, 32'd0}) begin
          n_err++; $display("FAIL sw_reset st=%0d req=%b we=%b pc_we=%b instret=%0d exp 0 0 0 0 0",
                            state, dmem_req, dmem_we, pc_we, instret); end
        tick;
      end else begin
        tick; dmem_ready = 1'b0; exp_ret++;
        n_cmp++; if ({state, instret} !== {3'd1, exp_ret}) begin
          n_err++; $display("FAIL sw retire st=%0d instret=%0d exp 1 %0d", state, instret, exp_ret); end
      end
    end
  endtask

  task automatic test_illegal;
    instr = 32'h0000007F; imem_ready = 1'b1; #1;
    tick;
    n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL illegal decode_state got %0d exp 2", state); end
    tick;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({state, trap, trap_cause, imem_req, pc_we, ir_we} !== {3'd6, 1'b1, 2'b01, 3'b000}) begin
        n_err++; $display("FAIL illegal trap%0d st=%0d trap=%b cause=%b req=%b pc_we=%b ir_we=%b exp 6 1 01 0 0 0",
                          i, state, trap, trap_cause, imem_req, pc_we, ir_we); end
      tick;
    end
    do_reset;
    n_cmp++; if ({state, trap, trap_cause} !== {3'd0, 3'b000}) begin
      n_err++; $display("FAIL illegal clear st=%0d trap=%b cause=%b exp 0 0 00", state, trap, trap_cause); end
    tick;
  endtask

  task automatic test_timeout;
    instr = 32'h002081B3; imem_ready = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({state, imem_req, ir_we} !== {3'd1, 2'b10}) begin
        n_err++; $display("FAIL timeout wait%0d st=%0d req=%b ir_we=%b exp 1 1 0", i, state, imem_req, ir_we); end
      tick;
    end
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b1; #1;
      n_cmp++; if ({state, trap, trap_cause, imem_req, ir_we} !== {3'd6, 1'b1, 2'b10, 2'b00}) begin
        n_err++; $display("FAIL timeout trap%0d st=%0d trap=%b cause=%b req=%b ir_we=%b exp 6 1 10 0 0",
                          i, state, trap, trap_cause, imem_req, ir_we); end
      tick;
    end
    do_reset;
    n_cmp++; if ({state, trap_cause, instret} !== {3'd0, 2'b00, 32'd0}) begin
      n_err++; $display("FAIL timeout clear st=%0d cause=%b instret=%0d exp 0 00 0", state, trap_cause, instret); end
  endtask

  initial begin
    reset = 1'b1; instr = 32'h0; imem_ready = 1'b0; dmem_ready = 1'b0;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
    test_reset;
    test_r_i_types;
    test_jumps_upper;
    test_load_wait;
    test_branch;
    test_store_and_reset;
    test_illegal;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
